branch_ctl_receiver: RTL

- Scheduler-side consumer of branch-resolution traffic (valid/wid/taken/dest) produced by the ALU branch unit.
- Tracks, per warp, whether a branch is outstanding, captures the resolved next PC, and presents one PC update at a time to the warp scheduler's PC table.
- Uses a ready/valid handshake and round-robin arbitration across warps.
- Drives the per-warp branch stall mask that gates issue.

---
 rtl/branch_ctl_receiver.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/branch_ctl_receiver.sv
// branch_ctl_receiver: scheduler-side consumer of branch resolutions.
// Keeps a small per-warp state machine (IDLE -> WAIT -> UPD -> IDLE), captures
// the resolved next PC and hands PC updates to the scheduler one at a time
// through a round-robin arbiter, while driving the per-warp issue stall mask.
module branch_ctl_receiver #(
    parameter  int NUM_WARPS = 4,
    parameter  int PC_BITS   = 30,
    parameter  int CNT_BITS  = 32,
    localparam int NW_WIDTH  = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 issue_valid,
    input  logic [NW_WIDTH-1:0]  issue_wid,
    input  logic [PC_BITS-1:0]   issue_next_pc,
    input  logic                 br_valid,
    input  logic [NW_WIDTH-1:0]  br_wid,
    input  logic                 br_taken,
    input  logic [PC_BITS-1:0]   br_dest,
    output logic                 upd_valid,
    output logic [NW_WIDTH-1:0]  upd_wid,
    output logic [PC_BITS-1:0]   upd_pc,
    input  logic                 upd_ready,
    output logic [NUM_WARPS-1:0] stall_mask,
    output logic                 err_sticky,
    output logic [CNT_BITS-1:0]  taken_cnt,
    output logic [CNT_BITS-1:0]  not_taken_cnt
);

    // WAIT: branch issued, resolution outstanding. UPD: resolved, PC update pending.
    typedef enum logic [1:0] {
        WS_IDLE = 2'd0,
        WS_WAIT = 2'd1,
        WS_UPD  = 2'd2
    } warp_state_e;

    warp_state_e         state_q   [NUM_WARPS];
    warp_state_e         state_d   [NUM_WARPS];
    logic [PC_BITS-1:0]  fall_pc_q [NUM_WARPS];
    logic [PC_BITS-1:0]  fall_pc_d [NUM_WARPS];
    logic [PC_BITS-1:0]  res_pc_q  [NUM_WARPS];
    logic [PC_BITS-1:0]  res_pc_d  [NUM_WARPS];
    logic [NW_WIDTH-1:0] rr_q;
    logic [NW_WIDTH-1:0] rr_d;
    logic                err_q;
    logic                err_d;
    logic [CNT_BITS-1:0] taken_q;
    logic [CNT_BITS-1:0] taken_d;
    logic [CNT_BITS-1:0] not_taken_q;
    logic [CNT_BITS-1:0] not_taken_d;

    logic                grant_found;
    logic [NW_WIDTH-1:0] scan_idx;
    logic                handshake;

    // Round-robin grant: first warp in UPD searching upward from rr+1 with wrap;
    // the pointer itself is checked last, so the last-served warp has lowest priority.
    always_comb begin
        grant_found = 1'b0;
        scan_idx    = '0;
        upd_wid     = '0;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            scan_idx = rr_q + i[NW_WIDTH-1:0];
            if (!grant_found && (state_q[scan_idx] == WS_UPD)) begin
                grant_found = 1'b1;
                upd_wid     = scan_idx;
            end
        end
        upd_valid = grant_found;
        upd_pc    = grant_found ? res_pc_q[upd_wid] : '0;
    end

    // Any warp that is not IDLE must be held off from issuing.
    always_comb begin
        stall_mask = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            stall_mask[w] = (state_q[w] != WS_IDLE);
        end
    end

    // Per-warp transitions plus the shared pointer, error flag and counters.
    // Illegal events only raise the error flag and never disturb warp state.
    always_comb begin
        state_d     = state_q;
        fall_pc_d   = fall_pc_q;
        res_pc_d    = res_pc_q;
        rr_d        = rr_q;
        err_d       = err_q;
        taken_d     = taken_q;
        not_taken_d = not_taken_q;
        handshake   = upd_valid && upd_ready;

        if (handshake) begin
            rr_d = upd_wid;
        end

        for (int w = 0; w < NUM_WARPS; w++) begin
            case (state_q[w])
                WS_IDLE: begin
                    if (issue_valid && (issue_wid == NW_WIDTH'(w))) begin
                        state_d[w]   = WS_WAIT;
                        fall_pc_d[w] = issue_next_pc;
                    end
                    if (br_valid && (br_wid == NW_WIDTH'(w))) begin
                        err_d = 1'b1;
                    end
                end
                WS_WAIT: begin
                    if (br_valid && (br_wid == NW_WIDTH'(w))) begin
                        state_d[w]  = WS_UPD;
                        res_pc_d[w] = br_taken ? br_dest : fall_pc_q[w];
                        if (br_taken) begin
                            taken_d = taken_q + CNT_BITS'(1);
                        end else begin
                            not_taken_d = not_taken_q + CNT_BITS'(1);
                        end
                    end
                    if (issue_valid && (issue_wid == NW_WIDTH'(w))) begin
                        err_d = 1'b1;
                    end
                end
                WS_UPD: begin
                    if (handshake && (upd_wid == NW_WIDTH'(w))) begin
                        state_d[w] = WS_IDLE;
                    end
                    if ((issue_valid && (issue_wid == NW_WIDTH'(w))) ||
                        (br_valid && (br_wid == NW_WIDTH'(w)))) begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    state_d[w] = WS_IDLE;
                end
            endcase
        end
    end

    // State registers; reset discards all outstanding and pending work at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                state_q[w]   <= WS_IDLE;
                fall_pc_q[w] <= '0;
                res_pc_q[w]  <= '0;
            end
            rr_q        <= NW_WIDTH'(NUM_WARPS - 1);
            err_q       <= 1'b0;
            taken_q     <= '0;
            not_taken_q <= '0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                state_q[w]   <= state_d[w];
                fall_pc_q[w] <= fall_pc_d[w];
                res_pc_q[w]  <= res_pc_d[w];
            end
            rr_q        <= rr_d;
            err_q       <= err_d;
            taken_q     <= taken_d;
            not_taken_q <= not_taken_d;
        end
    end

    assign err_sticky    = err_q;
    assign taken_cnt     = taken_q;
    assign not_taken_cnt = not_taken_q;

endmodule
